// File: rtl/grant_decoder_2to4.sv
// Grant-side decoder: turns a 2-bit target index into a one-hot grant held until ack or timeout,
// followed by one release cycle carrying the done pulse. Sticky error flags record timeouts and stray acks.
module grant_decoder_2to4 #(
    parameter int TIMEOUT = 8,
    parameter int TW      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_idx,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] ack,
    input  logic       clear_err,
    output logic [3:0] grant,
    output logic       done,
    output logic       timed_out,
    output logic       err_timeout,
    output logic [1:0] err_idx,
    output logic       err_stray
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [TW-1:0] r_cnt;
    logic [3:0]    r_grant;
    logic          r_done;
    logic          r_timed_out;
    logic          r_err_timeout;
    logic [1:0]    r_err_idx;
    logic          r_err_stray;

    state_t        w_state_next;
    logic [1:0]    w_idx_next;
    logic [TW-1:0] w_cnt_next;
    logic [3:0]    w_grant_next;
    logic          w_done_next;
    logic          w_timed_out_next;
    logic          w_err_timeout_next;
    logic [1:0]    w_err_idx_next;
    logic          w_err_stray_next;

    logic [3:0]    w_ack_hit_bits;
    logic [3:0]    w_ack_stray_bits;
    logic          w_ack_hit;
    logic          w_accept;

    // Split ack into the bit belonging to the latched target and everything else.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ack_split
            assign w_ack_hit_bits[gi]   = ack[gi] & (r_idx == 2'(gi));
            assign w_ack_stray_bits[gi] = ack[gi] & (r_idx != 2'(gi));
        end
    endgenerate

    assign w_ack_hit = |w_ack_hit_bits;
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_state_next       = r_state;
        w_idx_next         = r_idx;
        w_cnt_next         = r_cnt;
        w_grant_next       = r_grant;
        w_done_next        = 1'b0;
        w_timed_out_next   = r_timed_out;
        w_err_timeout_next = r_err_timeout && !clear_err;
        w_err_idx_next     = r_err_idx;
        w_err_stray_next   = r_err_stray && !clear_err;

        case (r_state)
            ST_IDLE: begin
                if (|ack) begin
                    w_err_stray_next = 1'b1;
                end
                if (w_accept) begin
                    w_idx_next   = in_idx;
                    w_grant_next = 4'b0001 << in_idx;
                    w_cnt_next   = '0;
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (|w_ack_stray_bits) begin
                    w_err_stray_next = 1'b1;
                end
                // A matching ack on the limit cycle wins over the timeout.
                if (w_ack_hit) begin
                    w_grant_next     = 4'b0000;
                    w_done_next      = 1'b1;
                    w_timed_out_next = 1'b0;
                    w_state_next     = ST_RELEASE;
                end else if (r_cnt == CNT_LAST) begin
                    w_grant_next       = 4'b0000;
                    w_done_next        = 1'b1;
                    w_timed_out_next   = 1'b1;
                    w_err_timeout_next = 1'b1;
                    w_err_idx_next     = r_idx;
                    w_state_next       = ST_RELEASE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_grant_next = 4'b0000;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'b00;
            r_cnt         <= '0;
            r_grant       <= 4'b0000;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_idx     <= 2'b00;
            r_err_stray   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_cnt         <= w_cnt_next;
            r_grant       <= w_grant_next;
            r_done        <= w_done_next;
            r_timed_out   <= w_timed_out_next;
            r_err_timeout <= w_err_timeout_next;
            r_err_idx     <= w_err_idx_next;
            r_err_stray   <= w_err_stray_next;
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign timed_out   = r_timed_out;
    assign err_timeout = r_err_timeout;
    assign err_idx     = r_err_idx;
    assign err_stray   = r_err_stray;

endmodule

// File: tb/tb_grant_decoder_2to4.sv
// Directed bench for grant_decoder_2to4 with TIMEOUT=4; each task drives one scenario and checks inline.
module tb_grant_decoder_2to4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_idx;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ack;
    logic       clear_err;
    logic [3:0] grant;
    logic       done;
    logic       timed_out;
    logic       err_timeout;
    logic [1:0] err_idx;
    logic       err_stray;

    int checks = 0;
    int errors = 0;

    grant_decoder_2to4 #(.TIMEOUT(4), .TW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_idx     (in_idx),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ack        (ack),
        .clear_err  (clear_err),
        .grant      (grant),
        .done       (done),
        .timed_out  (timed_out),
        .err_timeout(err_timeout),
        .err_idx    (err_idx),
        .err_stray  (err_stray)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_idx = 2'b00; in_valid = 1'b0; ack = 4'b0000; clear_err = 1'b0;
        tick(); tick();
        checks++;
        if ({grant, done, timed_out, err_timeout, err_idx, err_stray} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b",
                     {grant, done, timed_out, err_timeout, err_idx, err_stray}, 10'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b exp 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", in_ready); end
        $display("txn reset done");
    endtask

    // Handshake idx=2, ack on second grant cycle.
    task automatic test_ack();
        in_idx = 2'd2; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ack_handshake_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (grant !== 4'b0100 || done !== 1'b0) begin
            errors++; $display("FAIL ack_grant_c1 got grant=%b done=%b exp 0100/0", grant, done);
        end
        checks++;
        if ({err_timeout, err_stray} !== 2'b00) begin
            errors++; $display("FAIL ack_errs got %b exp 00", {err_timeout, err_stray});
        end
        tick();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL ack_grant_c2 got %b exp 0100", grant); end
        ack = 4'b0100;
        tick();
        ack = 4'b0000;
        checks++;
        if ({grant, done, timed_out, in_ready} !== 7'b0000_1_0_0) begin
            errors++; $display("FAIL ack_release got %b exp 0000100", {grant, done, timed_out, in_ready});
        end
        tick();
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL ack_back_idle got done=%b ready=%b exp 0/1", done, in_ready);
        end
        $display("txn idx=2 acked");
    endtask

    // idx=3 never acked: grant for 4 cycles, then timeout.
    task automatic test_timeout();
        in_idx = 2'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (grant !== 4'b1000 || done !== 1'b0) begin
                errors++; $display("FAIL to_grant_c%0d got grant=%b done=%b exp 1000/0", c, grant, done);
            end
            tick();
        end
        checks++;
        if ({grant, done, timed_out, err_timeout, err_idx} !== 9'b0000_1_1_1_11) begin
            errors++; $display("FAIL to_release got %b exp 000011111",
                              {grant, done, timed_out, err_timeout, err_idx});
        end
        tick();
        checks++;
        if (timed_out !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL to_timed_out_held got to=%b done=%b exp 1/0", timed_out, done);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || err_idx !== 2'd3) begin
            errors++; $display("FAIL to_clear got err_to=%b err_idx=%0d exp 0/3", err_timeout, err_idx);
        end
        $display("txn idx=3 timed out");
    endtask

    // idx=0; ack arrives on the limit cycle and must win.
    task automatic test_ack_at_limit();
        in_idx = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL lim_grant_c4 got %b exp 0001", grant); end
        ack = 4'b0001;
        tick();
        ack = 4'b0000;
        checks++;
        if ({done, timed_out, err_timeout} !== 3'b100) begin
            errors++; $display("FAIL lim_release got %b exp 100", {done, timed_out, err_timeout});
        end
        tick();
        $display("txn idx=0 acked at limit");
    endtask

    // idx=1 with a stray ack, valid held high across GRANT/RELEASE.
    task automatic test_stray_and_hold();
        in_idx = 2'd1; in_valid = 1'b1;
        tick();
        in_idx = 2'd2;
        ack = 4'b0001;
        tick();
        checks++;
        if (err_stray !== 1'b1 || grant !== 4'b0010) begin
            errors++; $display("FAIL stray_set got stray=%b grant=%b exp 1/0010", err_stray, grant);
        end
        ack = 4'b0010;
        tick();
        ack = 4'b0000;
        checks++;
        if ({grant, done, in_ready} !== 6'b0000_1_0) begin
            errors++; $display("FAIL stray_release got %b exp 000010", {grant, done, in_ready});
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_not_taken got grant=%b ready=%b exp 0000/1", grant, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL hold_taken got %b exp 0100", grant); end
        $display("txn idx=1 stray ack, idx=2 accepted after release");
    endtask

    // Reset on the second grant cycle of the idx=2 grant in flight.
    task automatic test_reset_mid_grant();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({grant, done, timed_out, err_timeout, err_idx, err_stray} !== 10'b0) begin
            errors++; $display("FAIL midrst_outputs got %b exp 0",
                              {grant, done, timed_out, err_timeout, err_idx, err_stray});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b exp 0", done); end
        in_idx = 2'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL midrst_regrant got %b exp 0010", grant); end
        ack = 4'b0010;
        tick();
        ack = 4'b0000;
        tick();
        $display("txn reset mid-grant, idx=1 regranted");
    endtask

    // A stray ack in IDLE coinciding with clear_err leaves the flag set.
    task automatic test_clear_priority();
        ack = 4'b1000; clear_err = 1'b1;
        tick();
        ack = 4'b0000; clear_err = 1'b0;
        checks++;
        if (err_stray !== 1'b1) begin errors++; $display("FAIL clr_set_wins got %b exp 1", err_stray); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++;
        if (err_stray !== 1'b0) begin errors++; $display("FAIL clr_plain got %b exp 0", err_stray); end
        $display("txn clear_err priority");
    endtask

    initial begin
        test_reset();
        test_ack();
        test_timeout();
        test_ack_at_limit();
        test_stray_and_hold();
        test_reset_mid_grant();
        test_clear_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
